exu_wb_arb: RTL and testbench
=============================

# exu_wb_arb

Parametrised writeback arbiter between the EXU functional units (ALU, MUL, DIV, MAC, LSU, and any added later) and the IDU1 register-file write port. It replaces the one-hot OR-mux writeback, which silently corrupts data when two units complete in the same cycle. Each source gets its own small FIFO, and the arbiter retires one result per cycle. It also exports stall and pending-destination information to issue logic.

## Interface
- `NUM_SRC`, default 5: number of writeback sources; range 2..8.
- `DEPTH`, default 2: entries per source FIFO; power of two, ≥2.
- `XLEN`, from global.svh: datapath width.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_valid` in NUM_SRC: per-source result valid, one cycle per result.
- `src_data` in NUM_SRC×XLEN: result data.
- `src_rd_addr` in NUM_SRC×5: destination register.
- `src_instr_tag` in NUM_SRC×XLEN: debug tag.
- `src_instr` in NUM_SRC×32: debug instruction.
- `src_full` out NUM_SRC: source FIFO full; the unit must hold its result (feeds the `*_busy` chain).
- `exu_wb_data` out XLEN: retired data.
- `exu_wb_rd_addr` out 5: retired destination.
- `exu_wb_rd_wr_en` out 1: register-file write strobe.
- `instr_tag_out` out XLEN: debug tag of the retired result.
- `instr_out` out 32: debug instruction of the retired result.
- `wb_pending` out 32: bit r is set while any queued entry targets x r; bit 0 is always 0.
- `wb_overflow` out 1: sticky; set when a push arrives while that source is full.

## Operation
- **Push:**
  - When `src_valid[i]` is high and `src_rd_addr[i]` is nonzero, the entry is written to FIFO i at the clock edge.
  - An entry with `rd=0` is discarded and never queued.
- **Overflow:**
  - `src_full[i]` is computed from the pre-edge count (count==DEPTH).
  - A push while full is dropped and sets `wb_overflow`.
  - A pop in the same cycle does not make room for that push.
- **Arbitration:**
  - Combinational, over the non-empty FIFO heads. Exactly one head is granted per cycle.
  - The granted head drives all `exu_wb_*` and debug outputs, with `exu_wb_rd_wr_en=1`.
  - The granted head is popped at the next edge.
  - With no head pending, all outputs are 0.
- **Ordering:** results from the same source retire in arrival order. Ordering across sources is not guaranteed; WAW between units is prevented by issue logic using `wb_pending`.
- **Push and pop on the same FIFO in one cycle:** both take effect, and the count is unchanged.
- **Empty FIFO:** an entry pushed into an empty FIFO is eligible for arbitration in the following cycle, not the same one.
- **Pointers:** read/write pointers are log2(DEPTH) bits and wrap naturally. Occupancy uses a separate counter of log2(DEPTH)+1 bits.
- **`wb_pending`:** the OR over all valid FIFO entries of onehot(rd). It includes the head being retired this cycle and clears the cycle after the pop.

## Timing
- Minimum latency is 1 cycle: `src_valid` in cycle N gives `exu_wb_rd_wr_en` in cycle N+1.
- Each competing head adds one cycle per higher-priority winner.
- Throughput is one writeback per cycle.
- `src_full` rises in the cycle after the DEPTH-th unpopped push. It falls in the cycle after a pop from a full FIFO.
- Reset, asynchronous: all FIFOs empty, pointers and counters 0, round-robin pointer 0, `wb_overflow` 0. All outputs are 0 while `rst_n` is low and in the first cycle after release.
- Reset asserted mid-operation discards every queued result. No writeback is produced for any of them.

## Configuration
- **`EXU_WB_RR_EN` defined:** round-robin arbitration.
  - A pointer holds the last granted index.
  - The search starts at last+1, modulo NUM_SRC.
  - The pointer updates only on a grant.
  - No source waits more than NUM_SRC−1 grants.
- **`EXU_WB_RR_EN` undefined:** fixed priority, lowest index wins (source 0 = ALU). No pointer register exists.

## Structure
- The `exu_wb_entry_t` typedef (data, rd_addr, instr_tag, instr) goes in types.svh.
- `NUM_WB_SRC_MAX` goes in global.svh.
- One sub-module, `exu_wb_fifo`, parametrised by DEPTH.
  - Ports: push, entry in, pop, head out, empty, full, plus a per-entry valid/rd vector for `wb_pending`.
  - It is instantiated NUM_SRC times in a generate loop.
- The arbiter, overflow flag and pending mask are inline in `exu_wb_arb`.

## Test plan
- **Single result:** src0 pushes rd=5, data=0xDEADBEEF in cycle N → cycle N+1 shows wr_en=1, rd=5, data=0xDEADBEEF, and `wb_pending[5]=1`. Cycle N+2 shows wr_en=0 and `wb_pending[5]=0`.
- **Collision, fixed priority:** src1 (rd=3) and src4 (rd=7) push in the same cycle N → rd=3 retires in N+1, then rd=7 in N+2. No corruption, and neither result is lost.
- **Round-robin:** with `EXU_WB_RR_EN`, src0 and src2 push every cycle → grants alternate 0, 2, 0, 2. Both FIFOs fill, `src_full[0]` and `src_full[2]` toggle, and no entry is dropped while the sources obey `src_full`.
- **Overflow:** DEPTH=2, src3 pushes 3 times in consecutive cycles while src0 wins continuously → the third push is dropped and `wb_overflow=1` stays set until reset. Exactly 2 src3 results retire, in order.
- **rd=0 and reset:** a push with rd=0 produces no writeback. With 4 entries queued, asserting `rst_n` low mid-drain makes all outputs 0 immediately, and no queued result retires after release.

Source files
------------

// File: rtl/exu_wb_arb_pkg.sv
// Shared types and constants for the EXU writeback arbiter.
// Holds the datapath width, the source-count ceiling and the queued
// writeback entry layout used by both the arbiter and its per-source FIFO.
package exu_wb_arb_pkg;

    localparam int XLEN           = 32;
    localparam int NUM_WB_SRC_MAX = 8;

    // One queued writeback result: data, destination and debug trace fields.
    typedef struct packed {
        logic [XLEN-1:0] data;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] instr_tag;
        logic [31:0]     instr;
    } exu_wb_entry_t;

endpackage

// File: rtl/exu_wb_fifo.sv
// Per-source writeback FIFO, DEPTH entries (power of two, >= 2).
// Pointers wrap naturally; occupancy is a separate counter one bit wider
// than the pointers so that full and empty are unambiguous.
// The caller never pushes while full nor pops while empty.
module exu_wb_fifo
    import exu_wb_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  exu_wb_entry_t         push_entry,
    input  logic                  pop,
    output exu_wb_entry_t         head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH-1:0]      ent_valid,
    output logic [DEPTH-1:0][4:0] ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    exu_wb_entry_t mem [DEPTH];

    // Pointer and occupancy bookkeeping; push+pop together leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are meaningful only where ent_valid is set.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [PW-1:0] offset;
        offset    = '0;
        ent_valid = '0;
        ent_rd    = '0;
        for (int j = 0; j < DEPTH; j++) begin
            offset       = PW'(j) - rd_ptr;
            ent_valid[j] = ({1'b0, offset} < count);
            ent_rd[j]    = mem[j].rd_addr;
        end
    end

endmodule

// File: rtl/exu_wb_arb.sv
// Writeback arbiter between the EXU functional units and the register-file
// write port. Each source owns a small FIFO; one head retires per cycle.
// Build option: define EXU_WB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest source index winning.
//
// Source handshake: a unit presents a result by raising src_valid[i] for one
// cycle, and may do so only while src_full[i] is low. A result presented
// while src_full[i] is high is dropped and latches wb_overflow. Results with
// rd=0 are discarded without being queued.
module exu_wb_arb
    import exu_wb_arb_pkg::*;
#(
    parameter int NUM_SRC = 5,
    parameter int DEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             src_valid,
    input  logic [NUM_SRC-1:0][XLEN-1:0]   src_data,
    input  logic [NUM_SRC-1:0][4:0]        src_rd_addr,
    input  logic [NUM_SRC-1:0][XLEN-1:0]   src_instr_tag,
    input  logic [NUM_SRC-1:0][31:0]       src_instr,
    output logic [NUM_SRC-1:0]             src_full,
    output logic [XLEN-1:0]                exu_wb_data,
    output logic [4:0]                     exu_wb_rd_addr,
    output logic                           exu_wb_rd_wr_en,
    output logic [XLEN-1:0]                instr_tag_out,
    output logic [31:0]                    instr_out,
    output logic [31:0]                    wb_pending,
    output logic                           wb_overflow
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0]     push_req;
    logic [NUM_SRC-1:0]     push_ok;
    logic [NUM_SRC-1:0]     pop;
    logic [NUM_SRC-1:0]     fifo_empty;
    logic [NUM_SRC-1:0]     fifo_full;
    exu_wb_entry_t          fifo_head    [NUM_SRC];
    logic [DEPTH-1:0]       fifo_ent_vld [NUM_SRC];
    logic [DEPTH-1:0][4:0]  fifo_ent_rd  [NUM_SRC];

    logic                   grant_vld;
    logic [IW-1:0]          grant_idx;
    logic [31:0]            pend;

    // Full is judged on the pre-edge count, so a same-cycle pop never admits a push.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        exu_wb_entry_t in_entry;

        assign in_entry = '{data:      src_data[i],
                            rd_addr:   src_rd_addr[i],
                            instr_tag: src_instr_tag[i],
                            instr:     src_instr[i]};

        assign push_req[i] = src_valid[i] && (src_rd_addr[i] != 5'd0);
        assign push_ok[i]  = push_req[i] && !fifo_full[i];
        assign pop[i]      = grant_vld && (grant_idx == IW'(i));

        exu_wb_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk        (clk),
            .rst_n      (rst_n),
            .push       (push_ok[i]),
            .push_entry (in_entry),
            .pop        (pop[i]),
            .head       (fifo_head[i]),
            .empty      (fifo_empty[i]),
            .full       (fifo_full[i]),
            .ent_valid  (fifo_ent_vld[i]),
            .ent_rd     (fifo_ent_rd[i])
        );
    end

    assign src_full = fifo_full;

`ifdef EXU_WB_RR_EN
    logic [IW-1:0] rr_ptr;

    // Round-robin pointer remembers the last granted source; idle cycles leave it alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_vld) begin
            rr_ptr <= grant_idx;
        end
    end

    // Round-robin search starting one past the last winner, wrapping at NUM_SRC.
    always_comb begin
        logic [IW-1:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IW'((int'(rr_ptr) + k) % NUM_SRC);
            if (!grant_vld && !fifo_empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end
`else
    // Fixed priority: scan downwards so the lowest non-empty index is the last write.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (!fifo_empty[IW'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(k);
            end
        end
    end
`endif

    // Granted head drives the write port; everything reads zero when nothing is queued.
    always_comb begin
        exu_wb_data     = '0;
        exu_wb_rd_addr  = '0;
        exu_wb_rd_wr_en = 1'b0;
        instr_tag_out   = '0;
        instr_out       = '0;
        if (grant_vld) begin
            exu_wb_data     = fifo_head[grant_idx].data;
            exu_wb_rd_addr  = fifo_head[grant_idx].rd_addr;
            exu_wb_rd_wr_en = 1'b1;
            instr_tag_out   = fifo_head[grant_idx].instr_tag;
            instr_out       = fifo_head[grant_idx].instr;
        end
    end

    // Pending mask: every live entry, including the head retiring this cycle.
    always_comb begin
        pend = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (fifo_ent_vld[s][j]) pend[fifo_ent_rd[s][j]] = 1'b1;
            end
        end
    end

    assign wb_pending = {pend[31:1], 1'b0};

    // Sticky overflow: any real push arriving at a full FIFO, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_overflow <= 1'b0;
        end else if (|(push_req & fifo_full)) begin
            wb_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_exu_wb_arb.sv
// Self-checking bench for exu_wb_arb (default build: fixed priority;
// round-robin expectations apply when EXU_WB_RR_EN is defined).
// A queue-per-source reference model predicts every output each cycle.
module tb_exu_wb_arb;

    localparam int NS    = 5;
    localparam int DEPTH = 2;
    localparam int XLEN  = 32;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- DUT ----------------
    logic [NS-1:0]           src_valid;
    logic [NS-1:0][XLEN-1:0] src_data;
    logic [NS-1:0][4:0]      src_rd_addr;
    logic [NS-1:0][XLEN-1:0] src_instr_tag;
    logic [NS-1:0][31:0]     src_instr;
    logic [NS-1:0]           src_full;
    logic [XLEN-1:0]         exu_wb_data;
    logic [4:0]              exu_wb_rd_addr;
    logic                    exu_wb_rd_wr_en;
    logic [XLEN-1:0]         instr_tag_out;
    logic [31:0]             instr_out;
    logic [31:0]             wb_pending;
    logic                    wb_overflow;

    exu_wb_arb #(
        .NUM_SRC (NS),
        .DEPTH   (DEPTH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_rd_addr     (src_rd_addr),
        .src_instr_tag   (src_instr_tag),
        .src_instr       (src_instr),
        .src_full        (src_full),
        .exu_wb_data     (exu_wb_data),
        .exu_wb_rd_addr  (exu_wb_rd_addr),
        .exu_wb_rd_wr_en (exu_wb_rd_wr_en),
        .instr_tag_out   (instr_tag_out),
        .instr_out       (instr_out),
        .wb_pending      (wb_pending),
        .wb_overflow     (wb_overflow)
    );

    // ---------------- scoreboard / reference model ----------------
    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] tag;
        logic [31:0] instr;
    } m_ent_t;

    m_ent_t mq [NS][$];
    int     m_last;
    logic   m_ovf;
    int     checks;
    int     failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Winner among the sources that have something queued this cycle.
    function automatic int pick();
        int c;
        pick = -1;
`ifdef EXU_WB_RR_EN
        for (int k = 1; k <= NS; k++) begin
            c = (m_last + k) % NS;
            if (pick < 0 && mq[c].size() != 0) pick = c;
        end
`else
        c = 0;
        for (int k = 0; k < NS; k++) begin
            if (pick < 0 && mq[k].size() != 0) pick = k;
        end
`endif
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) mq[i].delete();
        m_last = 0;
        m_ovf  = 1'b0;
    endfunction

    task automatic check_outputs();
        int          w;
        logic [31:0] pend;
        m_ent_t      e;
        w = pick();
        e.data = '0; e.rd = '0; e.tag = '0; e.instr = '0;
        if (w >= 0) e = mq[w][0];
        pend = '0;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < mq[i].size(); j++) pend[mq[i][j].rd] = 1'b1;
        pend[0] = 1'b0;
        chk("wr_en",      32'(exu_wb_rd_wr_en), 32'(w >= 0));
        chk("wb_rd",      32'(exu_wb_rd_addr),  32'(e.rd));
        chk("wb_data",    exu_wb_data,          e.data);
        chk("instr_tag",  instr_tag_out,        e.tag);
        chk("instr",      instr_out,            e.instr);
        chk("wb_pending", wb_pending,           pend);
        chk("overflow",   32'(wb_overflow),     32'(m_ovf));
        for (int i = 0; i < NS; i++)
            chk($sformatf("src_full%0d", i), 32'(src_full[i]), 32'(mq[i].size() == DEPTH));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int s, input logic [4:0] rd, input logic [31:0] data);
        src_valid[s]     = 1'b1;
        src_rd_addr[s]   = rd;
        src_data[s]      = data;
        src_instr_tag[s] = $urandom;
        src_instr[s]     = $urandom;
    endtask

    // Check the current cycle, advance the model across the edge, then release valids.
    task automatic tick();
        int sz [NS];
        int w;
        check_outputs();
        w = pick();
        for (int i = 0; i < NS; i++) sz[i] = mq[i].size();
        if (w >= 0) begin
            void'(mq[w].pop_front());
            m_last = w;
        end
        for (int i = 0; i < NS; i++) begin
            if (src_valid[i] && src_rd_addr[i] != 5'd0) begin
                if (sz[i] == DEPTH) m_ovf = 1'b1;
                else mq[i].push_back('{src_data[i], src_rd_addr[i], src_instr_tag[i], src_instr[i]});
            end
        end
        @(posedge clk);
        #1 src_valid = '0;
        @(negedge clk);
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        checks        = 0;
        failures      = 0;
        rst_n         = 1'b0;
        src_valid     = '0;
        src_data      = '0;
        src_rd_addr   = '0;
        src_instr_tag = '0;
        src_instr     = '0;
        model_reset();

        // Reset: everything zero while held and in the first cycle after release.
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        tick();

        // Single result with one-cycle latency, pending bit clears after the pop.
        drive(0, 5'd5, 32'hDEAD_BEEF);
        repeat (3) tick();

        // Collision between src1 and src4.
        drive(1, 5'd3, 32'h1111_0003);
        drive(4, 5'd7, 32'h4444_0007);
        repeat (3) tick();

        // rd=0 is discarded.
        drive(2, 5'd0, 32'h2222_0000);
        repeat (2) tick();

        // Overflow: src0 keeps winning while src3 pushes three times.
        for (int c = 0; c < 4; c++) begin
            drive(0, 5'(10 + c), 32'h0A00_0000 + 32'(c));
            if (c < 3) drive(3, 5'(20 + c), 32'h3000_0000 + 32'(c));
            tick();
        end
        repeat (4) tick();

        // Two sources streaming every cycle while honouring full.
        for (int c = 0; c < 12; c++) begin
            if (mq[0].size() < DEPTH) drive(0, 5'(1 + (c % 8)), 32'hA000_0000 + 32'(c));
            if (mq[2].size() < DEPTH) drive(2, 5'(16 + (c % 8)), 32'hC000_0000 + 32'(c));
            tick();
        end
        repeat (6) tick();

        // Randomised traffic, mostly obeying full with occasional violations.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 2) != 0 &&
                    (mq[i].size() < DEPTH || $urandom_range(0, 9) == 0))
                    drive(i, 5'($urandom_range(0, 31)), $urandom);
            end
            tick();
        end
        repeat (12) tick();

        // Mid-drain reset: four results queued, none may retire afterwards.
        drive(1, 5'd9,  32'h1000_0009);
        drive(2, 5'd12, 32'h2000_000C);
        drive(3, 5'd13, 32'h3000_000D);
        drive(4, 5'd14, 32'h4000_000E);
        tick();
        check_outputs();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
